// File: rtl/piece_queue.sv
// Random-piece consumer: requests values from the 3-bit LFSR, maps them to
// tetromino IDs and keeps a shift FIFO of upcoming pieces for spawn and preview.
module piece_queue #(
  parameter int DEPTH = 3,
  parameter int ID_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    rng_req,
  input  logic [ID_W-1:0]         rng_value,
  input  logic                    hold,
  input  logic                    spawn_req,
  output logic                    spawn_ack,
  output logic [ID_W-1:0]         spawn_piece,
  output logic [DEPTH*ID_W-1:0]   preview,
  output logic [2:0]              count,
  output logic                    ready
);

  localparam logic [2:0]      DEPTH_C = 3'(DEPTH);
  localparam logic [ID_W-1:0] ONE     = ID_W'(1);

  typedef enum logic [1:0] {REQ, CAP, IDLE} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] fifo_q [DEPTH];
  logic [ID_W-1:0] fifo_d [DEPTH];
  logic [2:0]      count_d;
  logic [2:0]      wr_idx;
  logic [ID_W-1:0] cap_id;
  logic            pop, cap, room;

  assign room   = count < DEPTH_C;
  assign pop    = spawn_req && (count != 3'd0) && !hold;
  assign cap    = (state == CAP);
  // Value 0 is the LFSR's lock-up state; treat it as piece 0 rather than wrapping to 7.
  assign cap_id = (rng_value == '0) ? '0 : rng_value - ONE;
  // After a same-cycle shift the tail slot moves down by one.
  assign wr_idx = pop ? count - 3'd1 : count;
  assign count_d = count + {2'b00, cap} - {2'b00, pop};
  assign ready  = (count == DEPTH_C);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) fifo_d[i] = fifo_q[i];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (cap && (3'(i) == wr_idx)) fifo_d[i] = cap_id;
    end
  end

  always_comb begin
    rng_req    = 1'b0;
    state_next = state;
    case (state)
      REQ: begin
        if (room && !hold && !reset) begin
          rng_req    = 1'b1;
          state_next = CAP;
        end else begin
          state_next = IDLE;
        end
      end
      // An issued request always completes, even under hold.
      CAP:     state_next = (count_d < DEPTH_C) ? REQ : IDLE;
      IDLE:    if (room && !hold) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  always_comb begin
    preview = '0;
    for (int i = 0; i < DEPTH; i++) preview[i*ID_W +: ID_W] = fifo_q[i];
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the FIFO storage is reset explicitly because preview must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      count       <= 3'd0;
      spawn_ack   <= 1'b0;
      spawn_piece <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state     <= state_next;
      count     <= count_d;
      spawn_ack <= pop;
      if (pop) spawn_piece <= fifo_q[0];
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= fifo_d[i];
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// Bench for piece_queue with a behavioural 3-bit LFSR generator; pops are
// checked by a scoreboard monitor that compares spawn_piece on every spawn_ack.
module tb_piece_queue;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rng_req;
  logic [2:0] rng_value;
  logic       hold = 1'b0;
  logic       spawn_req = 1'b0;
  logic       spawn_ack;
  logic [2:0] spawn_piece;
  logic [8:0] preview;
  logic [2:0] count;
  logic       ready;

  logic [2:0] lfsr;
  logic       force_zero = 1'b0;

  int tests = 0;
  int fails = 0;
  int ack_seen = 0;
  int exp_q[$];

  piece_queue #(.DEPTH(3), .ID_W(3)) dut (
    .clk(clk), .reset(reset), .rng_req(rng_req), .rng_value(rng_value),
    .hold(hold), .spawn_req(spawn_req), .spawn_ack(spawn_ack),
    .spawn_piece(spawn_piece), .preview(preview), .count(count), .ready(ready)
  );

  always #5 clk = ~clk;

  // Generator: 001 -> 100 -> 010 -> 101 -> 110 -> 111 -> 011 -> 001
  always @(posedge clk) begin
    if (reset) lfsr <= 3'b001;
    else if (rng_req) lfsr <= {lfsr[0] ^ lfsr[1], lfsr[2:1]};
  end
  assign rng_value = force_zero ? 3'b000 : lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] pv(input logic [2:0] head, input logic [2:0] mid,
                                    input logic [2:0] tail);
    return {tail, mid, head};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    #1;
    check("rst_rng_req", rng_req, 0);
    check("rst_spawn_ack", spawn_ack, 0);
    check("rst_spawn_piece", spawn_piece, 0);
    check("rst_preview", preview, 0);
    check("rst_count", count, 0);
    check("rst_ready", ready, 0);
    step();
    reset = 1'b0;
  endtask

  task automatic pop_expect(input int id);
    spawn_req = 1'b1;
    exp_q.push_back(id);
  endtask

  // Monitor: pops the scoreboard on each ack and watches global invariants.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (spawn_ack) begin
        ack_seen++;
        if (exp_q.size() == 0) check("spurious_ack", spawn_ack, 0);
        else check("spawn_piece", spawn_piece, exp_q.pop_front());
      end
      check("rng_req_b2b", prev_req & rng_req, 0);
      check("count_bound", count > 3'd3, 0);
      prev_req = rng_req;
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Fill from reset; spawn_req in cycle 1 hits an empty queue.
    spawn_req = 1'b1;
    do_reset();
    #1; check("c1_req", rng_req, 1); check("c1_count", count, 0);
    step(); spawn_req = 1'b0;
    #1; check("c2_req", rng_req, 0); check("c2_ack", spawn_ack, 0);
    step(); #1; check("c3_req", rng_req, 1); check("c3_preview", preview, pv(3, 0, 0));
    step(); #1; check("c4_req", rng_req, 0);
    step(); #1; check("c5_req", rng_req, 1); check("c5_count", count, 2);
    check("c5_preview", preview, pv(3, 1, 0));
    step(); #1; check("c6_req", rng_req, 0); check("c6_ready", ready, 0);
    step(); #1; check("c7_count", count, 3); check("c7_ready", ready, 1);
    check("c7_preview", preview, pv(3, 1, 4)); check("c7_req_full", rng_req, 0);
    check("c7_piece_empty_pop", spawn_piece, 0);

    // Single pop from full, then refill with 110.
    pop_expect(3);
    step(); spawn_req = 1'b0;
    #1; check("p_ack", spawn_ack, 1); check("p_piece", spawn_piece, 3);
    check("p_count", count, 2); check("p_preview", preview, pv(1, 4, 0));
    step(); #1; check("p_ack_once", spawn_ack, 0); check("p_req", rng_req, 1);
    step(); step(); #1; check("p_refill", preview, pv(1, 4, 5)); check("p_ready", ready, 1);

    // Level spawn_req from full; the empty cycle in the middle must not pop.
    do_reset();
    repeat (6) step();
    pop_expect(3);
    step(); exp_q.push_back(1);
    step(); exp_q.push_back(4);
    step(); #1; check("l_empty_count", count, 0);
    step(); exp_q.push_back(5);
    #1; check("l_count1", count, 1); check("l_head", preview, pv(5, 0, 0));
    step(); spawn_req = 1'b0;
    #1; check("l_last_piece", spawn_piece, 5); check("l_count0", count, 0);
    step(); #1; check("l_refill", preview, pv(6, 0, 0));

    // Hold from reset blocks requests and pops.
    hold = 1'b1;
    spawn_req = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1; check("h_req", rng_req, 0); check("h_count", count, 0);
      step();
    end
    hold = 1'b0;
    spawn_req = 1'b0;
    #1; check("h_rel_idle", rng_req, 0);
    step(); #1; check("h_rel_req", rng_req, 1);
    step(); step(); #1; check("h_first", preview, pv(3, 0, 0)); check("h_count1", count, 1);

    // Illegal value 0 maps to id 0; reset during CAP drops the capture.
    do_reset();
    step(); force_zero = 1'b1;
    step(); force_zero = 1'b0;
    #1; check("z_count", count, 1); check("z_id0", preview, pv(0, 0, 0));
    step(); step(); #1; check("z_next", preview, pv(0, 1, 0));
    step(); reset = 1'b1;
    #1; check("rc_req", rng_req, 0);
    step(); #1; check("rc_count", count, 0); check("rc_preview", preview, 0);
    reset = 1'b0;
    #1; check("rc_req_again", rng_req, 1);
    step(); step(); #1; check("rc_restart", preview, pv(3, 0, 0));

    // Pop and capture on the same edge with count=2.
    do_reset();
    repeat (5) step();
    pop_expect(3);
    step(); spawn_req = 1'b0;
    #1; check("pc_count", count, 2); check("pc_preview", preview, pv(1, 4, 0));
    check("pc_piece", spawn_piece, 3);

    repeat (3) step();
    check("pending_acks", exp_q.size(), 0);
    check("ack_total", ack_seen, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
